// File: rtl/io_timer_if.sv
// io_timer_if: address, strobe and interrupt signals between the processor datapath and the timer.
interface io_timer_if;
    logic [15:0] memAddr;
    logic        re_L;
    logic        we_L;
    logic        irq;

    modport master (output memAddr, output re_L, output we_L, input irq);
    modport slave  (input memAddr, input re_L, input we_L, output irq);
endinterface

// File: rtl/io_timer.sv
// io_timer: memory-mapped countdown timer with prescaler, auto-reload and level interrupt.
module io_timer #(
    parameter logic [15:0] BASE_ADDR = 16'h2010,
    parameter int          PRESCALE  = 16
) (
    input  logic         clock,
    input  logic         reset_L,
    io_timer_if.slave    bus,
    inout  wire   [15:0] dataBus
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t      r_state;
    logic        r_auto;
    logic        r_irqen;
    logic        r_done;
    logic [15:0] r_load;
    logic [15:0] r_count;
    logic [15:0] r_pre;

    logic [15:0] w_off;
    logic        w_hit;
    logic [1:0]  w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_run;
    logic        w_tick;
    logic [15:0] w_rdata;

    assign w_off  = bus.memAddr - BASE_ADDR;
    assign w_hit  = w_off < 16'd4;
    assign w_sel  = w_off[1:0];
    assign w_wr   = !bus.we_L && w_hit;
    // a simultaneous write strobe suppresses the read so the bus is never contended
    assign w_rd   = !bus.re_L && bus.we_L && w_hit;
    assign w_run  = r_state == RUN;
    assign w_tick = r_pre == 16'(PRESCALE - 1);

    assign w_rdata = w_sel == 2'd0 ? {13'b0, r_irqen, r_auto, w_run} :
                     w_sel == 2'd1 ? r_load :
                     w_sel == 2'd2 ? r_count :
                                     {14'b0, w_run, r_done};

    assign dataBus = w_rd ? w_rdata : 'z;
    assign bus.irq = r_done & r_irqen;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
            r_auto  <= 1'b0;
            r_irqen <= 1'b0;
            r_done  <= 1'b0;
            r_load  <= '0;
            r_count <= '0;
            r_pre   <= '0;
        end else begin
            if (w_wr && w_sel == 2'd1)
                r_load <= dataBus;
            // DONE clear comes first so a same-cycle expiry below overrides it
            if (w_wr && w_sel == 2'd3 && dataBus[0]) begin
                r_done <= 1'b0;
                if (r_state == EXPIRED)
                    r_state <= IDLE;
            end
            if (w_wr && w_sel == 2'd0) begin
                r_auto  <= dataBus[1];
                r_irqen <= dataBus[2];
                if (dataBus[0]) begin
                    r_count <= r_load;
                    r_pre   <= '0;
                    if (r_load == '0) begin
                        r_state <= EXPIRED;
                        r_done  <= 1'b1;
                    end else
                        r_state <= RUN;
                end else if (w_run)
                    r_state <= IDLE;
            end else if (w_run) begin
                r_pre <= w_tick ? '0 : r_pre + 16'd1;
                if (w_tick) begin
                    if (r_count > 16'd1)
                        r_count <= r_count - 16'd1;
                    else begin
                        r_done <= 1'b1;
                        if (r_auto)
                            r_count <= r_load;
                        else begin
                            r_count <= '0;
                            r_state <= EXPIRED;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed register-level checks of io_timer with PRESCALE=4 at base 16'h2010.
module tb_io_timer;
    logic        clock;
    logic        reset_L;
    logic        tb_oe;
    logic [15:0] tb_d;
    wire  [15:0] dataBus;
    int          n_chk;
    int          n_err;

    io_timer_if bus ();

    io_timer #(.BASE_ADDR(16'h2010), .PRESCALE(4)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus),
        .dataBus (dataBus)
    );

    assign dataBus = tb_oe ? tb_d : 'z;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        bus.memAddr = a;
        bus.re_L    = 1'b0;
        #1;
        chk(tag, dataBus, exp);
        bus.re_L = 1'b1;
    endtask

    // bench holds the bus at 0 so any DUT drive shows up as a nonzero or X value
    task automatic rd_z(input string tag, input logic [15:0] a, input logic re);
        bus.memAddr = a;
        bus.re_L    = re;
        tb_d        = 16'h0000;
        tb_oe       = 1'b1;
        #1;
        chk(tag, dataBus, 16'h0000);
        tb_oe    = 1'b0;
        bus.re_L = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.memAddr = a;
        tb_d        = d;
        tb_oe       = 1'b1;
        bus.we_L    = 1'b0;
        @(posedge clock);
        #1;
        bus.we_L = 1'b1;
        tb_oe    = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        reset_L     = 1'b0;
        tb_oe       = 1'b0;
        tb_d        = '0;
        bus.memAddr = '0;
        bus.re_L    = 1'b1;
        bus.we_L    = 1'b1;
        cyc(2);
        rd("rst_ctrl", 16'h2010, 16'h0000);
        rd("rst_load", 16'h2011, 16'h0000);
        rd("rst_count", 16'h2012, 16'h0000);
        rd("rst_status", 16'h2013, 16'h0000);
        chk("rst_irq", {15'b0, bus.irq}, 16'h0000);
        @(negedge clock);
        reset_L = 1'b1;
        cyc(1);

        wr(16'h2011, 16'd3);
        wr(16'h2010, 16'h0005);
        rd("one_status_run", 16'h2013, 16'h0002);
        rd("one_count3", 16'h2012, 16'd3);
        rd("one_ctrl", 16'h2010, 16'h0005);
        cyc(3);
        rd("one_count3_hold", 16'h2012, 16'd3);
        cyc(1);
        rd("one_count2", 16'h2012, 16'd2);
        cyc(4);
        rd("one_count1", 16'h2012, 16'd1);
        cyc(3);
        rd("one_pre_expire", 16'h2013, 16'h0002);
        chk("one_irq_low", {15'b0, bus.irq}, 16'h0000);
        cyc(1);
        rd("one_count0", 16'h2012, 16'd0);
        rd("one_status_done", 16'h2013, 16'h0001);
        rd("one_ctrl_en0", 16'h2010, 16'h0004);
        chk("one_irq_high", {15'b0, bus.irq}, 16'h0001);
        wr(16'h2013, 16'h0001);
        rd("one_cleared", 16'h2013, 16'h0000);
        chk("one_irq_clr", {15'b0, bus.irq}, 16'h0000);

        wr(16'h2011, 16'd2);
        wr(16'h2010, 16'h0003);
        rd("auto_count2", 16'h2012, 16'd2);
        cyc(4);
        rd("auto_count1", 16'h2012, 16'd1);
        cyc(4);
        rd("auto_reload", 16'h2012, 16'd2);
        rd("auto_status", 16'h2013, 16'h0003);
        cyc(8);
        rd("auto_reload2", 16'h2012, 16'd2);
        rd("auto_status2", 16'h2013, 16'h0003);
        wr(16'h2013, 16'h0001);
        rd("auto_done_clr", 16'h2013, 16'h0002);
        cyc(6);
        rd("race_count1", 16'h2012, 16'd1);
        wr(16'h2013, 16'h0001);
        rd("race_set_wins", 16'h2013, 16'h0003);
        rd("race_reload", 16'h2012, 16'd2);
        rd("race_ctrl", 16'h2010, 16'h0003);
        wr(16'h2010, 16'h0000);
        rd("auto_stop", 16'h2013, 16'h0001);
        rd("auto_stop_ctrl", 16'h2010, 16'h0000);
        wr(16'h2013, 16'h0000);
        rd("status_wr0", 16'h2013, 16'h0001);
        wr(16'h2013, 16'h0001);
        rd("auto_clr", 16'h2013, 16'h0000);

        wr(16'h2011, 16'd0);
        wr(16'h2010, 16'h0001);
        rd("zero_status", 16'h2013, 16'h0001);
        rd("zero_count", 16'h2012, 16'd0);
        rd("zero_ctrl", 16'h2010, 16'h0000);
        wr(16'h2013, 16'h0001);
        rd("zero_clr", 16'h2013, 16'h0000);

        wr(16'h2011, 16'd6);
        wr(16'h2010, 16'h0001);
        rd("stop_count6", 16'h2012, 16'd6);
        cyc(4);
        rd("stop_count5", 16'h2012, 16'd5);
        cyc(3);
        wr(16'h2010, 16'h0000);
        rd("stop_tick_drop", 16'h2012, 16'd5);
        rd("stop_idle", 16'h2013, 16'h0000);
        cyc(10);
        rd("stop_hold", 16'h2012, 16'd5);
        rd_z("z_addr2014", 16'h2014, 1'b0);
        rd_z("z_addr200f", 16'h200F, 1'b0);
        rd_z("z_re_high", 16'h2012, 1'b1);

        bus.memAddr = 16'h2011;
        tb_d        = 16'h1234;
        tb_oe       = 1'b1;
        bus.we_L    = 1'b0;
        bus.re_L    = 1'b0;
        #1;
        chk("rw_no_drive", dataBus, 16'h1234);
        @(posedge clock);
        #1;
        bus.we_L = 1'b1;
        bus.re_L = 1'b1;
        tb_oe    = 1'b0;
        rd("rw_written", 16'h2011, 16'h1234);

        wr(16'h2011, 16'd0);
        wr(16'h2010, 16'h0005);
        chk("pre_irq", {15'b0, bus.irq}, 16'h0001);
        wr(16'h2011, 16'd9);
        wr(16'h2010, 16'h0005);
        rd("mid_status", 16'h2013, 16'h0003);
        cyc(8);
        rd("mid_count7", 16'h2012, 16'd7);
        #2;
        reset_L = 1'b0;
        rd("ar_ctrl", 16'h2010, 16'h0000);
        rd("ar_load", 16'h2011, 16'h0000);
        rd("ar_count", 16'h2012, 16'h0000);
        rd("ar_status", 16'h2013, 16'h0000);
        chk("ar_irq", {15'b0, bus.irq}, 16'h0000);
        @(negedge clock);
        reset_L = 1'b1;
        cyc(20);
        rd("post_count", 16'h2012, 16'h0000);
        rd("post_status", 16'h2013, 16'h0000);
        chk("post_irq", {15'b0, bus.irq}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 Parameter BASE_ADDR, default 16'h2010: word address of the first of four consecutive registers.
REQ-002 Parameter PRESCALE, default 16: number of clock cycles per timer tick; legal range 2..65535.
REQ-003 Port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port reset_L, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 Port memAddr, input, 16: address from the datapath memory address register.
REQ-006 Port dataBus, inout, 16: shared processor data bus.
REQ-007 Port re_L, input, 1: active-low read strobe.
REQ-008 Port we_L, input, 1: active-low write strobe.
REQ-009 Port irq, output, 1: timer interrupt request, level.

Function
REQ-010 Register map SHALL be: BASE+0 CTRL (RW; bit0 EN, bit1 AUTO, bit2 IRQEN, bits 15:3 read 0); BASE+1 LOAD (RW, 16b); BASE+2 COUNT (RO, 16b); BASE+3 STATUS (bit0 DONE, bit1 RUNNING, bits 15:2 read 0).
REQ-011 Read: when re_L=0 and memAddr hits the map, the block SHALL combinationally drive the selected register onto dataBus; otherwise dataBus SHALL be high-Z.
REQ-012 Write: when we_L=0 and memAddr hits the map, the block SHALL capture dataBus at the rising edge; writes to COUNT SHALL be ignored.
REQ-013 re_L=0 and we_L=0 together SHALL be treated as a write only, with dataBus not driven.
REQ-014 FSM states SHALL be IDLE, RUN, EXPIRED; STATUS.RUNNING = (state==RUN); CTRL.EN reads 1 only in RUN.
REQ-015 IDLE/EXPIRED + CTRL write with EN=1: next cycle state=RUN, COUNT<=LOAD, prescaler<=0; if LOAD==0, next state SHALL instead be EXPIRED with DONE set.
REQ-016 RUN: prescaler increments each cycle; tick = (prescaler==PRESCALE-1), then prescaler wraps to 0.
REQ-017 RUN, tick, COUNT>1: COUNT decrements by 1.
REQ-018 RUN, tick, COUNT==1: DONE set; if AUTO=1, COUNT<=LOAD (value current that cycle) and state stays RUN; else COUNT<=0 and state<=EXPIRED.
REQ-019 RUN + CTRL write with EN=0: state<=IDLE, COUNT and prescaler hold; a pending tick in that cycle SHALL be discarded.
REQ-020 RUN + CTRL write with EN=1: restart per REQ-015 (COUNT reloaded, prescaler cleared).
REQ-021 LOAD writes during RUN SHALL not alter COUNT; they take effect at next start or auto-reload.
REQ-022 STATUS write with bit0=1 clears DONE; if state==EXPIRED, state<=IDLE; bit0=0 writes have no effect.
REQ-023 DONE set and clear in the same cycle: set SHALL win.
REQ-024 irq SHALL equal DONE & IRQEN, combinational from registered state, no extra latency.
REQ-025 COUNT never wraps below 0; prescaler never exceeds PRESCALE-1.

Reset
REQ-026 On reset_L=0, asynchronously: CTRL=0, LOAD=0, COUNT=0, prescaler=0, DONE=0, state=IDLE, irq=0, dataBus high-Z.
REQ-027 Reset asserted mid-RUN SHALL abort immediately with no DONE/irq pulse; after release the block remains IDLE until a CTRL write with EN=1.

Verification (PRESCALE=4, BASE_ADDR=16'h2010)
REQ-028 Write LOAD=3, CTRL=16'h0005 -> RUNNING=1 next cycle; COUNT 3->2->1->0 every 4 cycles; DONE=1, irq=1, state EXPIRED 12 cycles after start.
REQ-029 LOAD=2, CTRL=16'h0003 -> COUNT reloads to 2 every 8 cycles, DONE stays 1, RUNNING stays 1; write STATUS=1 -> DONE=0 while still running.
REQ-030 LOAD=0, CTRL=16'h0001 -> next cycle state EXPIRED, DONE=1, COUNT=0, RUNNING=0.
REQ-031 Mid-run write CTRL=0 at COUNT=5 -> IDLE, COUNT reads 5 indefinitely; reads of 16'h2012 drive 5; reads at 16'h2014 and with re_L=1 leave dataBus Z.
REQ-032 DONE clear write coinciding with final tick (COUNT==1) -> DONE reads 1 next cycle.
REQ-033 Assert reset_L=0 mid-run at COUNT=7 -> all registers 0, irq=0 within same cycle, no tick after release.
